// File: rtl/serial_xnor_compare.sv
// Serial word comparator: XNORs two LSB-first bit streams over a WIDTH-bit word
// and reports per-bit matches, match count and whole-word equality.
//
// state | meaning
// IDLE  | waiting for start, results from last word held
// RUN   | accepting bit pairs on bit_valid
// DONE  | word complete, done pulse for one cycle
module serial_xnor_compare #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             input1,
  input  logic             input2,
  output logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] match_vec,
  output logic [CW-1:0]    match_count,
  output logic             equal
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          x;
  logic [CW-1:0] count_nxt;
  logic          last_bit;

  always_comb begin
    x         = ~(input1 ^ input2);
    count_nxt = match_count + CW'(x);
    last_bit  = (idx == IW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      op          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_vec   <= '0;
      match_count <= '0;
      equal       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bit_valid) begin
            op             <= x;
            match_vec[idx] <= x;
            match_count    <= count_nxt;
            if (last_bit) begin
              // idx stays at WIDTH-1; only the next start clears it
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              equal <= (count_nxt == CW'(WIDTH));
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state       <= ST_RUN;
            busy        <= 1'b1;
            idx         <= '0;
            match_vec   <= '0;
            match_count <= '0;
            equal       <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_xnor_compare.sv
// Randomized scoreboard bench for serial_xnor_compare: expected word results are
// queued at start and checked by an independent monitor when done pulses.
module tb_serial_xnor_compare;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          bit_valid;
  logic          input1;
  logic          input2;
  logic          op;
  logic          busy;
  logic          done;
  logic [W-1:0]  match_vec;
  logic [CW-1:0] match_count;
  logic          equal;

  serial_xnor_compare #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bit_valid(bit_valid),
    .input1(input1),
    .input2(input2),
    .op(op),
    .busy(busy),
    .done(done),
    .match_vec(match_vec),
    .match_count(match_count),
    .equal(equal)
  );

  typedef struct {
    logic [W-1:0] vec;
    int           cnt;
    logic         eq;
    logic         op;
    int           done_cyc;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the word result follows directly from the two operand words.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int dcyc);
    exp_t e;
    e.vec      = ~(a ^ b);
    e.cnt      = $countones(e.vec);
    e.eq       = (a == b);
    e.op       = ~(a[W-1] ^ b[W-1]);
    e.done_cyc = dcyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("match_vec", int'(match_vec), int'(e.vec));
        check("match_count", int'(match_count), e.cnt);
        check("equal", int'(equal), int'(e.eq));
        check("op_last", int'(op), int'(e.op));
        check("busy_in_done", int'(busy), 0);
        check("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    start     = 1'b0;
    bit_valid = 1'($urandom);
    input1    = 1'($urandom);
    input2    = 1'($urandom);
  endtask

  // Entered just after a rising edge; returns in the DONE cycle of this word.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int gap, input bit mid_start);
    exp_t e;
    start     = 1'b1;
    bit_valid = 1'($urandom);
    input1    = 1'($urandom);
    input2    = 1'($urandom);
    e = model(a, b, cyc + 2 + (W - 1) * (gap + 1));
    q.push_back(e);
    last_exp = e;
    for (int i = 0; i < W; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          start     = 1'b0;
          bit_valid = 1'b0;
          input1    = 1'($urandom);
          input2    = 1'($urandom);
          check("busy_gap", int'(busy), 1);
        end
      end
      @(posedge clk); #1;
      start     = (mid_start && i == 4);
      bit_valid = 1'b1;
      input1    = a[i];
      input2    = b[i];
      check("busy_run", int'(busy), 1);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op"}, int'(op), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_vec"}, int'(match_vec), 0);
    check({tag, "_cnt"}, int'(match_count), 0);
    check({tag, "_equal"}, int'(equal), 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n     = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    input1    = 1'b0;
    input2    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    send_word(8'hA5, 8'hA5, 0, 1'b0);
    repeat (2) idle_cycle();
    send_word(8'hA5, 8'h5A, 0, 1'b0);
    repeat (2) idle_cycle();
    send_word(8'hF0, 8'hFF, 2, 1'b0);
    idle_cycle();

    // start pulse mid-word is ignored, then a back-to-back word from DONE
    send_word(8'h3C, 8'h35, 0, 1'b1);
    send_word(8'h00, 8'h00, 0, 1'b0);

    repeat (20) idle_cycle();
    check("hold_vec", int'(match_vec), int'(last_exp.vec));
    check("hold_cnt", int'(match_count), last_exp.cnt);
    check("hold_equal", int'(equal), int'(last_exp.eq));
    check("hold_op", int'(op), int'(last_exp.op));
    check("hold_busy", int'(busy), 0);

    // reset partway through a word: nothing of it may survive
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      bit_valid = 1'b1;
      input1    = 1'b1;
      input2    = 1'b1;
    end
    @(posedge clk); #1;
    bit_valid = 1'b0;
    check("midword_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midword_reset");
    #2;
    rst_n = 1'b1;
    repeat (12) idle_cycle();
    check("after_reset_busy", int'(busy), 0);
    check("after_reset_vec", int'(match_vec), 0);

    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      send_word(ra, rb, $urandom_range(0, 2), 1'($urandom));
      repeat ($urandom_range(0, 3)) idle_cycle();
    end

    repeat (4) idle_cycle();
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_xnor_compare.md
# serial_xnor_compare

Serial word comparator that sits directly downstream of the 2-input XNOR gate stage. Two bit-serial streams are XNORed bit by bit over a WIDTH-bit word. The block accumulates a per-bit match vector and a match count, and flags whole-word equality when the word completes. It is the first sequential consumer of XNOR outputs in the lab design and turns the gate's bit-level equality into a word-level result with a start/done handshake.

## Interface
- WIDTH, 8, bits per compared word (≥2)
- CW, $clog2(WIDTH+1), width of match_count (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new word; honoured only in IDLE or DONE
- bit_valid  input  1  input1/input2 carry a valid bit this cycle
- input1  input  1  serial bit of stream A, LSB first
- input2  input  1  serial bit of stream B, LSB first
- op  output  1  registered XNOR of the last accepted bit pair
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: word complete
- match_vec  output  WIDTH  bit i = XNOR of the i-th accepted pair
- match_count  output  CW  number of matching bit pairs in the word
- equal  output  1  match_count == WIDTH; valid from done until the next accepted start

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN; clear match_vec, match_count, equal and bit index.
  - Otherwise hold all outputs.
- RUN:
  - On each cycle with bit_valid=1, sample input1/input2 and compute x = ~(input1 ^ input2).
  - op <= x; match_vec[idx] <= x; match_count += x; idx++.
  - Cycles with bit_valid=0 change nothing; gaps of any length are allowed.
  - start is ignored in RUN.
- Word completion: when the accepted bit is index WIDTH-1 → DONE, and equal <= (final count == WIDTH).
- DONE:
  - done=1 for exactly this cycle.
  - start=1 here → RUN with clears, as from IDLE (back-to-back words).
  - Otherwise → IDLE.
- Results (match_vec, match_count, equal, op) hold from DONE until the next accepted start clears them.
- bit_valid outside RUN is ignored.
- match_count never exceeds WIDTH; idx wraps to 0 only via the start clear.
- Reset (rst_n=0, any time, including mid-word):
  - State goes to IDLE immediately.
  - op, busy, done, match_vec, match_count and equal all go to 0; idx goes to 0.
  - The partial word is discarded.

## Timing
- All state and outputs are registered on the rising clk edge except during asynchronous reset.
- start is sampled at edge N; busy=1 from edge N.
- The first bit can be accepted at edge N+1.
- The last bit is accepted at edge M; at edge M the block enters DONE, and done=1, busy=0 and final results are visible in cycle M..M+1.
- Minimum word time: WIDTH+1 cycles from start to done, with no gaps.
- Back-to-back: start held during the DONE cycle gives busy=1 in the next cycle with no IDLE cycle.
- op updates on the edge after each bit is accepted, so it lags one cycle behind the combinational gate.
- Reset release: the first start is sampled on the first edge with rst_n=1.

## Test plan
- Reset mid-word:
  - Stimulus: accept 3 bits, then pulse rst_n low between edges.
  - Required response: every output is 0 immediately, state is IDLE, and no done pulse follows.
- Equal word, no gaps:
  - Stimulus: A=0xA5, B=0xA5, WIDTH=8.
  - Required response: done exactly 9 cycles after start; match_vec=0xFF, match_count=8, equal=1.
- Inverted word:
  - Stimulus: A=0xA5, B=0x5A.
  - Required response: match_vec=0x00, match_count=0, equal=0, op=0 after the last bit.
- Gapped, partial match:
  - Stimulus: A=0xF0, B=0xFF, with bit_valid low for 2 cycles between each bit.
  - Required response: match_vec=0xF0, match_count=4, equal=0, done only after the 8th valid bit.
- Start during RUN and back-to-back:
  - Stimulus: pulse start at bit 4; then assert start in the DONE cycle with second word A=B=0x00.
  - Required response: the first pulse is ignored and the first word result is unaffected; the second word starts without an IDLE cycle and ends with count=8, equal=1.
- Hold:
  - Stimulus: after done, run 20 idle cycles with random input1/input2/bit_valid.
  - Required response: results are unchanged and busy=0.
